// File: rtl/generador_tubo.sv
// generador_tubo: producer side of the tube/bird collision interface.
//
// Purpose:
//   Generates the scrolling tube position for the collision checker and the
//   pixel renderer. X is the tube column and Y is the top edge of a fixed
//   96-pixel gap. The block freezes play when the checker raises its stop
//   flag, and it keeps the player score.
//
// Ports:
//   iClk         system clock
//   iReset_n     synchronous active-low reset
//   iTickFrame   one-cycle strobe, once per video frame
//   iStart       one-cycle start/restart pulse (debounced button)
//   iStop        collision flag from the checker (level)
//   oPosicionXT  tube column (10 bits)
//   oPosicionYT  gap top (9 bits)
//   oPuntaje     score, saturating at 255
//   oJugando     high while in CORRE
//   oEstado      00 ESPERA, 01 CORRE, 10 CHOQUE
//
// Build option:
//   TUBO_ACELERACION_EN  When defined, the scroll speed starts at VEL on each
//                        start. It rises by 1 every 8 points and is capped at
//                        VEL_MAX. When undefined, the speed is the constant VEL.
//
// Parameter constraint: Y_MIN + 255 <= 384, so that a random gap always fits.
//
// state  | meaning
// -------+-----------------------------------------------------------
// ESPERA | idle; tube parked at X_INICIO/Y_INICIAL, waiting for iStart
// CORRE  | playing; tube scrolls left on every frame tick, score counts
// CHOQUE | collision seen; everything frozen until iStart
module generador_tubo #(
  parameter logic [9:0] X_INICIO  = 10'd640,
  parameter logic [8:0] Y_INICIAL = 9'd200,
  parameter logic [8:0] Y_MIN     = 9'd40,
  parameter logic [3:0] VEL       = 4'd2,
  parameter logic [9:0] PASO_X    = 10'd64,
  parameter logic [3:0] VEL_MAX   = 4'd6
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iTickFrame,
  input  logic       iStart,
  input  logic       iStop,
  output logic [9:0] oPosicionXT,
  output logic [8:0] oPosicionYT,
  output logic [7:0] oPuntaje,
  output logic       oJugando,
  output logic [1:0] oEstado
);

  typedef enum logic [1:0] {
    ESPERA = 2'b00,
    CORRE  = 2'b01,
    CHOQUE = 2'b10
  } estadoT;

  estadoT      estado;
  logic [9:0]  posX;
  logic [8:0]  posY;
  logic [7:0]  puntaje;
  logic        jugando;
  logic [15:0] lfsr;

  logic [3:0]  velActual;
  logic [9:0]  velExt;
  logic        hayWrap;
  logic [9:0]  xResta;
  logic        cruzaPaso;
  logic        puntajeLleno;
  logic [7:0]  puntajeMas;
  logic [8:0]  yAleatorio;
  logic        lfsrFb;

`ifdef TUBO_ACELERACION_EN
  logic [3:0]  velocidad;
  assign velActual = velocidad;
`else
  assign velActual = VEL;
`endif

  assign velExt       = {6'd0, velActual};
  // A tube closer to the left edge than one step re-enters from the right
  // instead of being subtracted, so X never underflows.
  assign hayWrap      = posX < velExt;
  assign xResta       = posX - velExt;
  // Points are scored on the downward crossing of PASO_X. The caller only
  // uses this on the non-wrap path, so a wrap never scores.
  assign cruzaPaso    = (posX >= PASO_X) && (xResta < PASO_X);
  assign puntajeLleno = (puntaje == 8'hFF);
  assign puntajeMas   = puntaje + 8'd1;
  // Y_MIN + 255 stays within the 9-bit range, so this zero-extended add
  // cannot overflow.
  assign yAleatorio   = Y_MIN + {1'b0, lfsr[7:0]};
  // Right-shifting Fibonacci LFSR, taps 16,14,13,11 (bits 0,2,3,5 here).
  assign lfsrFb       = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      estado    <= ESPERA;
      posX      <= X_INICIO;
      posY      <= Y_INICIAL;
      puntaje   <= 8'd0;
      jugando   <= 1'b0;
      lfsr      <= 16'hACE1;
`ifdef TUBO_ACELERACION_EN
      velocidad <= VEL;
`endif
    end else begin
      // The LFSR keeps running in every state. The gap height therefore
      // depends on how long the player waited before pressing start.
      lfsr <= {lfsrFb, lfsr[15:1]};

      case (estado)
        ESPERA: begin
          posX <= X_INICIO;
          posY <= Y_INICIAL;
          if (iStart) begin
            estado    <= CORRE;
            jugando   <= 1'b1;
            puntaje   <= 8'd0;
`ifdef TUBO_ACELERACION_EN
            velocidad <= VEL;
`endif
          end
        end

        CORRE: begin
          // A collision takes priority over the frame tick and over iStart.
          if (iStop) begin
            estado  <= CHOQUE;
            jugando <= 1'b0;
          end else if (iTickFrame) begin
            if (hayWrap) begin
              posX <= X_INICIO;
              posY <= yAleatorio;
            end else begin
              posX <= xResta;
              if (cruzaPaso && !puntajeLleno) begin
                puntaje <= puntajeMas;
`ifdef TUBO_ACELERACION_EN
                if ((puntajeMas[2:0] == 3'b000) && (velocidad < VEL_MAX))
                  velocidad <= velocidad + 4'd1;
`endif
              end
            end
          end
        end

        CHOQUE: begin
          // The score is left untouched so it stays on screen until the next start.
          if (iStart) begin
            estado <= ESPERA;
            posX   <= X_INICIO;
            posY   <= Y_INICIAL;
          end
        end

        default: begin
          estado  <= ESPERA;
          jugando <= 1'b0;
          posX    <= X_INICIO;
          posY    <= Y_INICIAL;
        end
      endcase
    end
  end

  assign oPosicionXT = posX;
  assign oPosicionYT = posY;
  assign oPuntaje    = puntaje;
  assign oJugando    = jugando;
  assign oEstado     = estado;

endmodule

// File: tb/tb_generador_tubo.sv
module tb_generador_tubo;

  logic       iClk = 1'b0;
  logic       iReset_n = 1'b0;
  logic       iTickFrame = 1'b0;
  logic       iStart = 1'b0;
  logic       iStop = 1'b0;
  logic [9:0] oPosicionXT;
  logic [8:0] oPosicionYT;
  logic [7:0] oPuntaje;
  logic       oJugando;
  logic [1:0] oEstado;

  generador_tubo dut (
    .iClk        (iClk),
    .iReset_n    (iReset_n),
    .iTickFrame  (iTickFrame),
    .iStart      (iStart),
    .iStop       (iStop),
    .oPosicionXT (oPosicionXT),
    .oPosicionYT (oPosicionYT),
    .oPuntaje    (oPuntaje),
    .oJugando    (oJugando),
    .oEstado     (oEstado)
  );

  always #5 iClk = ~iClk;

  // One row: inputs held for 'reps' cycles, then the spec values that must
  // be visible afterwards (-1 = not checked by the row).
  typedef struct {
    logic  rstn;
    logic  tick;
    logic  start;
    logic  stop;
    int    reps;
    int    expX;
    int    expY;
    int    expP;
    int    expE;
    string name;
  } vecT;

  typedef struct {
    int x;
    int y;
    int p;
    int e;
    int j;
  } espT;

  vecT  tabla[$];
  espT  sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int          mX, mY, mP, mE, mVel;
  logic [15:0] mLfsr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] esp);
    checks++;
    if (act !== esp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, esp);
    end
  endtask

  task automatic modelStep(input logic rstn, input logic tick, input logic start, input logic stop);
    logic [15:0] l;
    int nx;
    if (!rstn) begin
      mX = 640; mY = 200; mP = 0; mE = 0; mVel = 2; mLfsr = 16'hACE1;
    end else begin
      l = mLfsr;
      case (mE)
        0: if (start) begin
             mE = 1; mP = 0; mVel = 2;
           end
        1: if (stop) mE = 2;
           else if (tick) begin
             if (mX < mVel) begin
               mX = 640;
               mY = 40 + int'(l & 16'h00FF);
             end else begin
               nx = mX - mVel;
               if (mX >= 64 && nx < 64 && mP < 255) begin
                 mP = mP + 1;
`ifdef TUBO_ACELERACION_EN
                 if ((mP % 8) == 0 && mVel < 6) mVel = mVel + 1;
`endif
               end
               mX = nx;
             end
           end
        default: if (start) begin
             mE = 0; mX = 640; mY = 200;
           end
      endcase
      mLfsr = {^(l & 16'h002D), l[15:1]};
    end
  endtask

  // Drives one clock of stimulus, records the model's prediction, and checks it
  // against the DUT half a period after the edge.
  task automatic cycle(input logic rstn, input logic tick, input logic start, input logic stop);
    espT e;
    iReset_n = rstn; iTickFrame = tick; iStart = start; iStop = stop;
    modelStep(rstn, tick, start, stop);
    sb.push_back('{mX, mY, mP, mE, (mE == 1) ? 1 : 0});
    @(posedge iClk);
    @(negedge iClk);
    e = sb.pop_front();
    chk("x", 32'(oPosicionXT), 32'(e.x));
    chk("y", 32'(oPosicionYT), 32'(e.y));
    chk("puntaje", 32'(oPuntaje), 32'(e.p));
    chk("estado", 32'(oEstado), 32'(e.e));
    chk("jugando", 32'(oJugando), 32'(e.j));
  endtask

  function automatic vecT mk(input logic r, input logic t, input logic s, input logic p,
                             input int n, input int x, input int y, input int pu, input int es,
                             input string nm);
    vecT v;
    v.rstn = r; v.tick = t; v.start = s; v.stop = p; v.reps = n;
    v.expX = x; v.expY = y; v.expP = pu; v.expE = es; v.name = nm;
    return v;
  endfunction

  initial begin
    int xa;
    //                rst tck st sp reps   X    Y    P   E
    tabla.push_back(mk(0, 0, 0, 0,   2, 640, 200,  0, 0, "reset"));
    tabla.push_back(mk(1, 1, 0, 0,   5, 640, 200,  0, 0, "espera ticks"));
    tabla.push_back(mk(1, 1, 0, 1,   3, 640, 200,  0, 0, "espera stop"));
    tabla.push_back(mk(1, 0, 1, 0,   1, 640, 200,  0, 1, "start"));
    tabla.push_back(mk(1, 1, 0, 0, 288,  64, 200,  0, 1, "tick 288"));
    tabla.push_back(mk(1, 1, 0, 0,   1,  62, 200,  1, 1, "tick 289"));
    tabla.push_back(mk(1, 1, 0, 0,  31,   0, 200,  1, 1, "tick 320"));
    tabla.push_back(mk(1, 1, 0, 0,   1, 640,  -1,  1, 1, "wrap"));
    tabla.push_back(mk(1, 0, 0, 0,   4, 640,  -1,  1, 1, "no tick"));
    tabla.push_back(mk(1, 0, 1, 0,   1, 640,  -1,  1, 1, "start in corre"));
    tabla.push_back(mk(1, 1, 0, 0, 270, 100,  -1,  1, 1, "to x100"));
    tabla.push_back(mk(1, 1, 0, 1,   1, 100,  -1,  1, 2, "stop+tick"));
    tabla.push_back(mk(1, 1, 0, 0,   5, 100,  -1,  1, 2, "choque ticks"));
    tabla.push_back(mk(1, 1, 0, 1,   2, 100,  -1,  1, 2, "choque stop"));
    tabla.push_back(mk(1, 0, 1, 0,   1, 640, 200,  1, 0, "restart"));
    tabla.push_back(mk(1, 0, 1, 0,   1, 640, 200,  0, 1, "start 2"));
    tabla.push_back(mk(1, 1, 0, 0, 170, 300, 200,  0, 1, "to x300"));
    tabla.push_back(mk(0, 1, 0, 0,   1, 640, 200,  0, 0, "reset mid"));
    tabla.push_back(mk(1, 0, 0, 0,   1, 640, 200,  0, 0, "after reset"));
    tabla.push_back(mk(1, 0, 1, 0,   1, 640, 200,  0, 1, "start 3"));
    tabla.push_back(mk(1, 1, 0, 0,  10, 620, 200,  0, 1, "to x620"));
    tabla.push_back(mk(1, 1, 1, 1,   1, 620, 200,  0, 2, "start+stop"));

    foreach (tabla[i]) begin
      for (int k = 0; k < tabla[i].reps; k++)
        cycle(tabla[i].rstn, tabla[i].tick, tabla[i].start, tabla[i].stop);
      if (tabla[i].expX >= 0) chk({tabla[i].name, " X"}, 32'(oPosicionXT), 32'(tabla[i].expX));
      if (tabla[i].expY >= 0) chk({tabla[i].name, " Y"}, 32'(oPosicionYT), 32'(tabla[i].expY));
      if (tabla[i].expP >= 0) chk({tabla[i].name, " P"}, 32'(oPuntaje), 32'(tabla[i].expP));
      if (tabla[i].expE >= 0) chk({tabla[i].name, " E"}, 32'(oEstado), 32'(tabla[i].expE));
    end

`ifdef TUBO_ACELERACION_EN
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    chk("accel start", 32'(oEstado), 32'd1);
    for (int k = 0; k < 4000 && mP < 8; k++) cycle(1, 1, 0, 0);
    chk("accel points", 32'(oPuntaje), 32'd8);
    xa = int'(oPosicionXT);
    cycle(1, 1, 0, 0);
    chk("accel step", 32'(xa - int'(oPosicionXT)), 32'd3);
    xa = int'(oPosicionXT);
    cycle(1, 1, 0, 0);
    chk("accel step 2", 32'(xa - int'(oPosicionXT)), 32'd3);
`else
    xa = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/generador_tubo.md
Name: generador_tubo

Overview:
- Producer side of the tube/bird collision interface.
- Generates the scrolling tube position: X is the tube column, 10 bits; Y is the top edge of the gap, 9 bits, with a fixed 96-pixel gap below it.
- Feeds these positions to the collision checker and the pixel renderer.
- Consumes the checker's stop flag to freeze play, and keeps the player score.

Parameters:
- X_INICIO, 640, X loaded at reset, on restart and on wrap.
- Y_INICIAL, 200, gap top used for the first tube after reset/restart.
- Y_MIN, 40, minimum random gap top. Constraint: Y_MIN+255 <= 384.
- VEL, 2, pixels subtracted from X per frame tick (1..15).
- PASO_X, 64, X threshold whose downward crossing scores a point.
- VEL_MAX, 6, speed ceiling, used only with TUBO_ACELERACION_EN.

Ports:
- iClk, input, 1, system clock.
- iReset_n, input, 1, synchronous active-low reset.
- iTickFrame, input, 1, one-cycle strobe, once per video frame.
- iStart, input, 1, one-cycle start/restart pulse from the button debouncer.
- iStop, input, 1, collision flag from the checker (level).
- oPosicionXT, output, 10, tube column.
- oPosicionYT, output, 9, gap top.
- oPuntaje, output, 8, score.
- oJugando, output, 1, high in state CORRE.
- oEstado, output, 2, 00 ESPERA, 01 CORRE, 10 CHOQUE.

Behaviour:
- Reset, sampled on iClk rising edge while iReset_n=0:
  - state=ESPERA, oPosicionXT=X_INICIO, oPosicionYT=Y_INICIAL, oPuntaje=0, oJugando=0.
  - LFSR loaded with 16'hACE1.
  - Reset overrides every other input in the same cycle.
- All outputs are registered; the next-state value is visible 1 cycle after the causing edge.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, shifts every clock in all states.
  - It never reaches all-zero; the seed is nonzero.
- ESPERA:
  - Positions are held at X_INICIO/Y_INICIAL; iTickFrame and iStop are ignored.
  - iStart -> CORRE, oPuntaje cleared to 0 in the same edge.
- CORRE:
  - iStop=1 takes priority: -> CHOQUE; positions and score are not updated that cycle, even if iTickFrame=1.
  - Otherwise, on iTickFrame:
    - If X < VEL (wrap): X <= X_INICIO, Y <= Y_MIN + lfsr[7:0] (9-bit zero-extended add, always <= 384).
    - Else: X <= X - VEL (never underflows).
    - Score: if the old X >= PASO_X and the new, non-wrapped X < PASO_X, oPuntaje increments. It saturates at 255.
    - A wrap never scores.
  - iStart is ignored in CORRE.
- CHOQUE:
  - Positions and score are frozen; iTickFrame and iStop are ignored.
  - iStart -> ESPERA, X <= X_INICIO, Y <= Y_INICIAL. The score is kept for display until the next start.
- Without iTickFrame, positions never change in any state.
- Simultaneous iStart and iStop in CORRE: iStop wins.

Optional Feature:
- Macro TUBO_ACELERACION_EN.
- When defined:
  - An internal 4-bit speed register is loaded with VEL on entry to CORRE.
  - Each score increment whose new oPuntaje is a multiple of 8 raises the speed by 1, capped at VEL_MAX.
  - The wrap test and the subtraction use the current speed instead of VEL.
- When undefined: speed is the constant VEL and no speed register exists.

Test Plan:
- Hold iReset_n=0 for 2 clocks, then release -> X=640, Y=200, oPuntaje=0, oEstado=00. Ticks in ESPERA -> X stays 640.
- iStart, then 289 iTickFrame pulses -> X=62, oPuntaje=1. Tick 288 gives X=64 with oPuntaje=0.
- Continue to tick 320 -> X=0. Tick 321 -> X=640, Y = 40 + lfsr[7:0], matching a bench LFSR model; oPuntaje unchanged at 1.
- In CORRE at X=100, assert iStop together with iTickFrame -> oEstado=10, X stays 100. Further ticks -> no change. iStart -> oEstado=00, X=640, Y=200, oPuntaje retained.
- Assert iReset_n=0 for 1 clock mid-CORRE at X=300 -> X=640, Y=200, oPuntaje=0, ESPERA on the next cycle.
- With TUBO_ACELERACION_EN: drive 8 scoring passes -> speed becomes 3, and X decrements by 3 per tick after the 8th point.
